// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants and source-code helpers for the forwarding/hazard unit.
package fwd_hazard_unit_pkg;

  // Operand comes straight from the register-file value latched in ID/EX.
  localparam int FWD_RF = 0;

  // Select code for producer stage j (0 = youngest).
  function automatic int fwd_stage_code(input int j);
    return j + 1;
  endfunction

  // Select code for the per-operand hold register, given N_FWD stages.
  function automatic int fwd_hold_code(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/fwd_operand_slice.sv
// One EX source operand: producer match/priority, load-use flag and the
// hold register that keeps a retiring WB value alive while EX is frozen.
module fwd_operand_slice
  import fwd_hazard_unit_pkg::*;
#(
  parameter int N_FWD  = 2,
  parameter int REG_W  = 5,
  parameter int WORD_W = 32,
  parameter int SEL_W  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ren_i,
  input  logic [REG_W-1:0]        rsel_i,
  input  logic [WORD_W-1:0]       rdat_i,
  input  logic                    ex_hold_i,
  input  logic                    ex_advance_i,
  input  logic [N_FWD-1:0]        prod_wen_i,
  input  logic [N_FWD*REG_W-1:0]  prod_wsel_i,
  input  logic [N_FWD-1:0]        prod_ready_i,
  input  logic [N_FWD*WORD_W-1:0] prod_data_i,
  output logic [SEL_W-1:0]        sel_o,
  output logic [WORD_W-1:0]       data_o,
  output logic                    not_ready_o
);

  logic [N_FWD-1:0]  match_s;
  logic              hit_s;
  logic              hit_ready_s;
  logic [SEL_W-1:0]  hit_code_s;
  logic [WORD_W-1:0] hit_data_s;
  logic              younger_s;
  logic              capture_s;

  logic              hold_valid_q, hold_valid_d;
  logic [WORD_W-1:0] hold_data_q,  hold_data_d;

  // Per-stage match; register 0 is hardwired and never matches.
  always_comb begin
    match_s = '0;
    for (int j = 0; j < N_FWD; j++) begin
      match_s[j] = ren_i && (rsel_i != '0) && prod_wen_i[j] &&
                   (prod_wsel_i[j*REG_W +: REG_W] == rsel_i);
    end
  end

  // Pick the youngest matching stage; scanning oldest-to-youngest lets the youngest win.
  always_comb begin
    hit_s       = 1'b0;
    hit_ready_s = 1'b0;
    hit_code_s  = SEL_W'(FWD_RF);
    hit_data_s  = '0;
    for (int j = N_FWD - 1; j >= 0; j--) begin
      if (match_s[j]) begin
        hit_s       = 1'b1;
        hit_ready_s = prod_ready_i[j];
        hit_code_s  = SEL_W'(fwd_stage_code(j));
        hit_data_s  = prod_data_i[j*WORD_W +: WORD_W];
      end
    end
  end

  // Any match in a stage younger than the oldest blocks hold capture.
  always_comb begin
    younger_s = 1'b0;
    for (int j = 0; j < N_FWD - 1; j++) begin
      younger_s = younger_s | match_s[j];
    end
  end

  // Capture only the value retiring from the oldest stage while EX is frozen.
  assign capture_s = ex_hold_i && !ex_advance_i && match_s[N_FWD-1] &&
                     prod_ready_i[N_FWD-1] && !younger_s;

  // Source select: a not-ready youngest match stalls and falls back to RF.
  always_comb begin
    sel_o       = SEL_W'(FWD_RF);
    data_o      = rdat_i;
    not_ready_o = 1'b0;
    if (hit_s) begin
      if (hit_ready_s) begin
        sel_o  = hit_code_s;
        data_o = hit_data_s;
      end else begin
        not_ready_o = 1'b1;
      end
    end else if (hold_valid_q) begin
      sel_o  = SEL_W'(fwd_hold_code(N_FWD));
      data_o = hold_data_q;
    end else begin
      sel_o  = SEL_W'(FWD_RF);
    end
  end

  // Hold next state: advance releases (and beats capture), capture loads/overwrites.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (ex_advance_i) begin
      hold_valid_d = 1'b0;
    end else if (capture_s) begin
      hold_valid_d = 1'b1;
      hold_data_d  = prod_data_i[(N_FWD-1)*WORD_W +: WORD_W];
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  // Hold register state, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit beside the EX stage: one operand
// slice per source, a combined stall and a saturating stall-cycle counter.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int N_SRC  = 2,
  parameter int N_FWD  = 2,
  parameter int REG_W  = 5,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16,
  localparam int SEL_W = $clog2(N_FWD + 2)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_SRC-1:0]        ex_ren,
  input  logic [N_SRC*REG_W-1:0]  ex_rsel,
  input  logic [N_SRC*WORD_W-1:0] ex_rdat,
  input  logic                    ex_hold,
  input  logic                    ex_advance,
  input  logic [N_FWD-1:0]        prod_wen,
  input  logic [N_FWD*REG_W-1:0]  prod_wsel,
  input  logic [N_FWD-1:0]        prod_ready,
  input  logic [N_FWD*WORD_W-1:0] prod_data,
  input  logic                    cnt_clr,
  output logic [N_SRC*SEL_W-1:0]  fwd_sel,
  output logic [N_SRC*WORD_W-1:0] fwd_data,
  output logic                    hazard_stall,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_SRC-1:0] not_ready_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar i = 0; i < N_SRC; i++) begin : g_slice
    fwd_operand_slice #(
      .N_FWD (N_FWD),
      .REG_W (REG_W),
      .WORD_W(WORD_W),
      .SEL_W (SEL_W)
    ) u_slice (
      .clk_i       (CLK),
      .rst_i       (RST),
      .ren_i       (ex_ren[i]),
      .rsel_i      (ex_rsel[i*REG_W +: REG_W]),
      .rdat_i      (ex_rdat[i*WORD_W +: WORD_W]),
      .ex_hold_i   (ex_hold),
      .ex_advance_i(ex_advance),
      .prod_wen_i  (prod_wen),
      .prod_wsel_i (prod_wsel),
      .prod_ready_i(prod_ready),
      .prod_data_i (prod_data),
      .sel_o       (fwd_sel[i*SEL_W +: SEL_W]),
      .data_o      (fwd_data[i*WORD_W +: WORD_W]),
      .not_ready_o (not_ready_s[i])
    );
  end

  assign hazard_stall = |not_ready_s;
  assign stall_cnt    = cnt_q;

  // Counter next state: clear beats increment, increment saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hazard_stall && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stall counter register, cleared asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
